pc_flag_unit: RTL and testbench

Program-counter and processor-status block sitting directly downstream of the multicycle controller. Consumes the controller's `pcAdd`/`pcJump`/`pcBranch` strobes, `flagOp`, `flagWrite` and sign-extended immediate. Holds the architectural PC and the five-bit PSR (C, L, F, Z, N), evaluates branch/jump conditions against the registered PSR, and supplies the link value for JAL. Also keeps a retired-instruction counter and a sticky control-error flag for debug.

---
 rtl/pc_flag_unit_pkg.sv | 32 +++
 rtl/pc_flag_unit_if.sv | 32 +++
 rtl/pc_flag_unit_cond_eval.sv | 40 ++++
 rtl/pc_flag_unit.sv | 76 +++++++
 tb/tb_pc_flag_unit.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/pc_flag_unit_pkg.sv
// Shared constants for the PC / processor-status block: condition codes,
// PSR bit positions and the default reset PC.
package pc_flag_unit_pkg;

  localparam int unsigned RETIRED_W = 16;
  localparam logic [15:0] PC_RESET_DEFAULT = 16'h0000;

  // PSR layout {C,L,F,Z,N}
  localparam int unsigned PSR_C = 4;
  localparam int unsigned PSR_L = 3;
  localparam int unsigned PSR_F = 2;
  localparam int unsigned PSR_Z = 1;
  localparam int unsigned PSR_N = 0;

  localparam logic [3:0] CC_EQ  = 4'b0000;
  localparam logic [3:0] CC_NE  = 4'b0001;
  localparam logic [3:0] CC_CS  = 4'b0010;
  localparam logic [3:0] CC_CC  = 4'b0011;
  localparam logic [3:0] CC_HI  = 4'b0100;
  localparam logic [3:0] CC_LS  = 4'b0101;
  localparam logic [3:0] CC_GT  = 4'b0110;
  localparam logic [3:0] CC_LE  = 4'b0111;
  localparam logic [3:0] CC_FS  = 4'b1000;
  localparam logic [3:0] CC_FC  = 4'b1001;
  localparam logic [3:0] CC_LO  = 4'b1010;
  localparam logic [3:0] CC_HS  = 4'b1011;
  localparam logic [3:0] CC_LT  = 4'b1100;
  localparam logic [3:0] CC_GE  = 4'b1101;
  localparam logic [3:0] CC_UC  = 4'b1110;
  localparam logic [3:0] CC_JAL = 4'b1111;

endpackage

// File: rtl/pc_flag_unit_if.sv
// Controller-to-PC/PSR signal bundle; master is the controller side.
interface pc_flag_unit_if #(
  parameter int unsigned WIDTH = 16
);
  import pc_flag_unit_pkg::*;

  logic                 pc_add;
  logic                 pc_jump;
  logic                 pc_branch;
  logic [3:0]           flag_op;
  logic                 flag_write;
  logic [4:0]           alu_flags;
  logic [WIDTH-1:0]     imm;
  logic [WIDTH-1:0]     jump_target;
  logic [WIDTH-1:0]     pc;
  logic [WIDTH-1:0]     pc_link;
  logic [4:0]           psr;
  logic                 cond_true;
  logic                 taken;
  logic [RETIRED_W-1:0] retired;
  logic                 ctrl_err;

  modport master (
    output pc_add, pc_jump, pc_branch, flag_op, flag_write, alu_flags, imm, jump_target,
    input  pc, pc_link, psr, cond_true, taken, retired, ctrl_err
  );

  modport slave (
    input  pc_add, pc_jump, pc_branch, flag_op, flag_write, alu_flags, imm, jump_target,
    output pc, pc_link, psr, cond_true, taken, retired, ctrl_err
  );
endinterface

// File: rtl/pc_flag_unit_cond_eval.sv
// Combinational branch-condition evaluation of a condition code against the PSR.
module pc_flag_unit_cond_eval
  import pc_flag_unit_pkg::*;
(
  input  logic [3:0] flag_op,
  input  logic [4:0] psr,
  output logic       cond_true
);

  logic c, l, f, z, n;

  assign c = psr[PSR_C];
  assign l = psr[PSR_L];
  assign f = psr[PSR_F];
  assign z = psr[PSR_Z];
  assign n = psr[PSR_N];

  always_comb begin
    cond_true = 1'b0;
    unique case (flag_op)
      CC_EQ:  cond_true = z;
      CC_NE:  cond_true = ~z;
      CC_CS:  cond_true = c;
      CC_CC:  cond_true = ~c;
      CC_HI:  cond_true = l;
      CC_LS:  cond_true = ~l;
      CC_GT:  cond_true = n;
      CC_LE:  cond_true = ~n;
      CC_FS:  cond_true = f;
      CC_FC:  cond_true = ~f;
      CC_LO:  cond_true = ~l & ~z;
      CC_HS:  cond_true = l | z;
      CC_LT:  cond_true = ~n & ~z;
      CC_GE:  cond_true = n | z;
      CC_UC:  cond_true = 1'b1;
      CC_JAL: cond_true = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_flag_unit.sv
// Architectural PC and PSR, jump/branch resolution, JAL link value,
// retired-instruction counter and sticky multi-strobe error flag.
module pc_flag_unit
  import pc_flag_unit_pkg::*;
#(
  parameter int unsigned     WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(PC_RESET_DEFAULT)
) (
  input logic           clk,
  input logic           reset,
  pc_flag_unit_if.slave bus
);

  logic [WIDTH-1:0]     pc_q, pc_d, pc_inc;
  logic [4:0]           psr_q, psr_d;
  logic                 taken_q, taken_d;
  logic [RETIRED_W-1:0] retired_q, retired_d;
  logic                 err_q, err_d;
  logic                 cond_true;
  logic                 any_strobe, multi_strobe;

  pc_flag_unit_cond_eval u_cond_eval (
    .flag_op   (bus.flag_op),
    .psr       (psr_q),
    .cond_true (cond_true)
  );

  assign pc_inc       = pc_q + WIDTH'(1);
  assign any_strobe   = bus.pc_add | bus.pc_jump | bus.pc_branch;
  assign multi_strobe = (bus.pc_add & bus.pc_jump) | (bus.pc_add & bus.pc_branch) |
                        (bus.pc_jump & bus.pc_branch);

  always_comb begin
    pc_d      = pc_q;
    taken_d   = taken_q;
    psr_d     = bus.flag_write ? bus.alu_flags : psr_q;
    retired_d = any_strobe ? retired_q + RETIRED_W'(1) : retired_q;
    err_d     = err_q | multi_strobe;
    // Condition always sees the registered PSR, even if flag_write is high this cycle.
    if (bus.pc_jump) begin
      pc_d    = cond_true ? bus.jump_target : pc_inc;
      taken_d = cond_true;
    end else if (bus.pc_branch) begin
      pc_d    = cond_true ? pc_q + bus.imm : pc_inc;
      taken_d = cond_true;
    end else if (bus.pc_add) begin
      pc_d    = pc_inc;
      taken_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      psr_q     <= '0;
      taken_q   <= 1'b0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      psr_q     <= psr_d;
      taken_q   <= taken_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_link   = pc_inc;
  assign bus.psr       = psr_q;
  assign bus.cond_true = cond_true;
  assign bus.taken     = taken_q;
  assign bus.retired   = retired_q;
  assign bus.ctrl_err  = err_q;

endmodule

// File: tb/tb_pc_flag_unit.sv
// Scoreboard bench for pc_flag_unit: the driver queues hand-computed post-edge
// state per cycle, an independent monitor pops and compares after each edge.
module tb_pc_flag_unit;

  logic clk;
  logic reset;

  pc_flag_unit_if #(.WIDTH(16)) bus ();

  pc_flag_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned cyc;
    logic [6:0]  mask;  // {cond, err, ret, taken, psr, link, pc}
    logic [15:0] pc;
    logic [4:0]  psr;
    logic        taken;
    logic [15:0] ret;
    logic        err;
    logic        cond;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  logic        done   = 1'b0;

  localparam logic [6:0] M_ALL  = 7'b111_1111;
  localparam logic [6:0] M_NOCD = 7'b011_1111;

  task automatic cmp(input string name, input string field, input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %h, expected %h", name, field, act, req);
    end
  endtask

  // Monitor: one registered-output snapshot per cycle, 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        if (e.mask[0]) cmp(e.name, "pc", bus.pc, e.pc);
        if (e.mask[1]) cmp(e.name, "pc_link", bus.pc_link, e.pc + 16'h1);
        if (e.mask[2]) cmp(e.name, "psr", 16'(bus.psr), 16'(e.psr));
        if (e.mask[3]) cmp(e.name, "taken", 16'(bus.taken), 16'(e.taken));
        if (e.mask[4]) cmp(e.name, "retired", bus.retired, e.ret);
        if (e.mask[5]) cmp(e.name, "ctrl_err", 16'(bus.ctrl_err), 16'(e.err));
        if (e.mask[6]) cmp(e.name, "cond_true", 16'(bus.cond_true), 16'(e.cond));
      end
    end
  end

  // str = {jump, branch, add}
  task automatic step(input string name, input logic rst_v, input logic [2:0] str,
                      input logic [3:0] op, input logic fw, input logic [4:0] flags,
                      input logic [15:0] im, input logic [15:0] tgt, input logic [6:0] m,
                      input logic [15:0] e_pc, input logic [4:0] e_psr, input logic e_tk,
                      input logic [15:0] e_ret, input logic e_err, input logic e_cond);
    exp_t e;
    reset           = rst_v;
    bus.pc_jump     = str[2];
    bus.pc_branch   = str[1];
    bus.pc_add      = str[0];
    bus.flag_op     = op;
    bus.flag_write  = fw;
    bus.alu_flags   = flags;
    bus.imm         = im;
    bus.jump_target = tgt;
    e.name  = name;
    e.cyc   = cyc + 1;
    e.mask  = m;
    e.pc    = e_pc;
    e.psr   = e_psr;
    e.taken = e_tk;
    e.ret   = e_ret;
    e.err   = e_err;
    e.cond  = e_cond;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    // name        rst  {j,b,a} op      fw flags     imm       target    mask    pc       psr    tk ret  er cd
    step("reset0",  0, 3'b001, 4'b0000, 0, 5'b00000, 16'h0000, 16'h0000, M_ALL, 16'h0000, 5'h00, 0, 0,  0, 0);
    step("reset1",  0, 3'b001, 4'b0000, 0, 5'b00000, 16'h0000, 16'h0000, M_ALL, 16'h0000, 5'h00, 0, 0,  0, 0);
    step("seq1",    1, 3'b001, 4'b0000, 0, 5'b00000, 16'h0000, 16'h0000, M_ALL, 16'h0001, 5'h00, 0, 1,  0, 0);
    step("seq2",    1, 3'b001, 4'b0000, 0, 5'b00000, 16'h0000, 16'h0000, M_ALL, 16'h0002, 5'h00, 0, 2,  0, 0);
    step("seq3",    1, 3'b001, 4'b0000, 0, 5'b00000, 16'h0000, 16'h0000, M_ALL, 16'h0003, 5'h00, 0, 3,  0, 0);
    step("jmp10",   1, 3'b100, 4'b1110, 1, 5'b00010, 16'h0000, 16'h0010, M_ALL, 16'h0010, 5'h02, 1, 4,  0, 1);
    step("br_eq",   1, 3'b010, 4'b0000, 0, 5'b00000, 16'hFFFE, 16'h0000, M_ALL, 16'h000E, 5'h02, 1, 5,  0, 1);
    step("br_ne",   1, 3'b010, 4'b0001, 0, 5'b00000, 16'hFFFE, 16'h0000, M_ALL, 16'h000F, 5'h02, 0, 6,  0, 0);
    step("jmp20",   1, 3'b100, 4'b1110, 0, 5'b00000, 16'h0000, 16'h0020, M_ALL, 16'h0020, 5'h02, 1, 7,  0, 1);
    step("jal_add", 1, 3'b001, 4'b0000, 0, 5'b00000, 16'h0000, 16'h0000, M_ALL, 16'h0021, 5'h02, 0, 8,  0, 1);
    step("jal_jmp", 1, 3'b100, 4'b1111, 0, 5'b00000, 16'h0000, 16'h0100, M_ALL, 16'h0100, 5'h02, 1, 9,  0, 1);
    step("stall",   1, 3'b000, 4'b0000, 0, 5'b00000, 16'h0000, 16'h0000, M_ALL, 16'h0100, 5'h02, 1, 9,  0, 1);
    step("jmpffff", 1, 3'b100, 4'b1110, 0, 5'b00000, 16'h0000, 16'hFFFF, M_ALL, 16'hFFFF, 5'h02, 1, 10, 0, 1);
    step("wrapadd", 1, 3'b001, 4'b0000, 0, 5'b00000, 16'h0000, 16'h0000, M_ALL, 16'h0000, 5'h02, 0, 11, 0, 1);
    step("jmpfff2", 1, 3'b100, 4'b1110, 0, 5'b00000, 16'h0000, 16'hFFFF, M_ALL, 16'hFFFF, 5'h02, 1, 12, 0, 1);
    step("wrap_br", 1, 3'b010, 4'b1110, 0, 5'b00000, 16'h0002, 16'h0000, M_ALL, 16'h0001, 5'h02, 1, 13, 0, 1);
    step("clrflag", 1, 3'b000, 4'b0000, 1, 5'b00000, 16'h0000, 16'h0000, M_ALL, 16'h0001, 5'h00, 1, 13, 0, 0);
    step("fw_br",   1, 3'b010, 4'b0000, 1, 5'b00010, 16'h0040, 16'h0000, M_ALL, 16'h0002, 5'h02, 0, 14, 0, 1);
    step("cc_cs",   1, 3'b000, 4'b0010, 1, 5'b10000, 16'h0000, 16'h0000, M_ALL, 16'h0002, 5'h10, 0, 14, 0, 1);
    step("cc_fs",   1, 3'b000, 4'b1000, 1, 5'b00100, 16'h0000, 16'h0000, M_ALL, 16'h0002, 5'h04, 0, 14, 0, 1);
    step("cc_ge",   1, 3'b000, 4'b1101, 1, 5'b00001, 16'h0000, 16'h0000, M_ALL, 16'h0002, 5'h01, 0, 14, 0, 1);
    step("cc_lo1",  1, 3'b000, 4'b1010, 1, 5'b00000, 16'h0000, 16'h0000, M_ALL, 16'h0002, 5'h00, 0, 14, 0, 1);
    step("cc_lo0",  1, 3'b000, 4'b1010, 1, 5'b01000, 16'h0000, 16'h0000, M_ALL, 16'h0002, 5'h08, 0, 14, 0, 0);
    step("cc_lt",   1, 3'b000, 4'b1100, 1, 5'b00001, 16'h0000, 16'h0000, M_ALL, 16'h0002, 5'h01, 0, 14, 0, 0);
    step("conflict",1, 3'b110, 4'b1110, 0, 5'b00000, 16'h0005, 16'h0100, M_ALL, 16'h0100, 5'h01, 1, 15, 1, 1);
    step("sticky",  1, 3'b001, 4'b0000, 0, 5'b00000, 16'h0000, 16'h0000, M_ALL, 16'h0101, 5'h01, 0, 16, 1, 0);
    step("reset2",  0, 3'b111, 4'b1110, 1, 5'b11111, 16'h0000, 16'h0200, M_NOCD, 16'h0000, 5'h00, 0, 0, 0, 0);
    step("postrst", 1, 3'b001, 4'b0000, 0, 5'b00000, 16'h0000, 16'h0000, M_ALL, 16'h0001, 5'h00, 0, 1,  0, 0);
    bus.pc_add = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    cmp("drain", "pending", 16'(sb.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
